// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use interlock and branch/jump flush control.
// Optional HAZ_PERF_EN adds free-running stall/flush event counters.
module id_ex_pipe #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              PCSrcE,
   input  logic [REG_AW-1:0] RS1D,
   input  logic [REG_AW-1:0] RS2D,
   input  logic [REG_AW-1:0] RDD,
   input  logic [XLEN-1:0]   RD1D,
   input  logic [XLEN-1:0]   RD2D,
   input  logic [XLEN-1:0]   ImmExtD,
   input  logic [XLEN-1:0]   PCD,
   input  logic [XLEN-1:0]   PCPlus4D,
   input  logic              RegWriteD,
   input  logic              MemWriteD,
   input  logic              JumpD,
   input  logic              BranchD,
   input  logic              ALUSrcD,
   input  logic [1:0]        ResultSrcD,
   input  logic [2:0]        ALUControlD,
   output logic [REG_AW-1:0] RS1E,
   output logic [REG_AW-1:0] RS2E,
   output logic [REG_AW-1:0] RDE,
   output logic [XLEN-1:0]   RD1E,
   output logic [XLEN-1:0]   RD2E,
   output logic [XLEN-1:0]   ImmExtE,
   output logic [XLEN-1:0]   PCE,
   output logic [XLEN-1:0]   PCPlus4E,
   output logic              RegWriteE,
   output logic              MemWriteE,
   output logic              JumpE,
   output logic              BranchE,
   output logic              ALUSrcE,
   output logic [1:0]        ResultSrcE,
   output logic [2:0]        ALUControlE,
   output logic              ValidE,
   output logic              StallF,
   output logic              StallD,
   output logic              FlushD,
   output logic              FlushE
`ifdef HAZ_PERF_EN
   ,
   output logic [31:0]       StallCount,
   output logic [31:0]       FlushCount
`endif
);

   logic load_use;

   // x0 as a load destination is architecturally dead, so it never interlocks.
   assign load_use = ValidE && (ResultSrcE == 2'b01) && (RDE != '0) &&
                     ((RDE == RS1D) || (RDE == RS2D));

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      if (reset) begin
         if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
         end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset || FlushE) begin
         RS1E        <= '0;
         RS2E        <= '0;
         RDE         <= '0;
         RD1E        <= '0;
         RD2E        <= '0;
         ImmExtE     <= '0;
         PCE         <= '0;
         PCPlus4E    <= '0;
         RegWriteE   <= 1'b0;
         MemWriteE   <= 1'b0;
         JumpE       <= 1'b0;
         BranchE     <= 1'b0;
         ALUSrcE     <= 1'b0;
         ResultSrcE  <= 2'b00;
         ALUControlE <= 3'b000;
         ValidE      <= 1'b0;
      end else begin
         RS1E        <= RS1D;
         RS2E        <= RS2D;
         RDE         <= RDD;
         RD1E        <= RD1D;
         RD2E        <= RD2D;
         ImmExtE     <= ImmExtD;
         PCE         <= PCD;
         PCPlus4E    <= PCPlus4D;
         RegWriteE   <= RegWriteD;
         MemWriteE   <= MemWriteD;
         JumpE       <= JumpD;
         BranchE     <= BranchD;
         ALUSrcE     <= ALUSrcD;
         ResultSrcE  <= ResultSrcD;
         ALUControlE <= ALUControlD;
         ValidE      <= 1'b1;
      end
   end

`ifdef HAZ_PERF_EN
   // Counters wrap naturally at 32 bits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         StallCount <= '0;
         FlushCount <= '0;
      end else begin
         if (load_use && !PCSrcE) StallCount <= StallCount + 32'd1;
         if (PCSrcE)              FlushCount <= FlushCount + 32'd1;
      end
   end
`endif

endmodule
